// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, FSM states,
// default latencies and small op-class helpers.
// The optional accumulate ops (codes 7-10) are enabled by MDU_MADD_EN.
package mdu_pkg;

  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mduStateE;

  function automatic logic isMultOp(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU);
  endfunction

  function automatic logic isDivOp(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic isMaddOp(input logic [3:0] op);
    return (op >= MDU_MADD) && (op <= MDU_MSUBU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational arithmetic core of the MDU: produces the 64-bit {HI,LO}
// result for the given op from the operands and the current HI/LO.
// Accumulate ops exist only when MDU_MADD_EN is defined.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic signed [63:0] aWide;
  logic signed [63:0] bWide;
  logic [63:0]        prodSigned;
  logic [63:0]        prodUnsigned;
  logic               divOverflow;
  logic [31:0]        divisor;
  logic signed [31:0] aSigned;
  logic signed [31:0] bSigned;
  logic [31:0]        quotSigned;
  logic [31:0]        remSigned;
  logic [31:0]        quotUnsigned;
  logic [31:0]        remUnsigned;

  assign aWide        = {{32{a[31]}}, a};
  assign bWide        = {{32{b[31]}}, b};
  assign prodSigned   = aWide * bWide;
  assign prodUnsigned = {32'd0, a} * {32'd0, b};

  // A zero divisor and the INT_MIN / -1 case are both steered to a divide
  // by one: the zero case is discarded later, and INT_MIN / 1 already
  // yields the required quotient 0x80000000 with remainder 0.
  assign divOverflow  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign divisor      = ((b == 32'd0) || divOverflow) ? 32'd1 : b;
  assign aSigned      = a;
  assign bSigned      = divisor;
  assign quotSigned   = aSigned / bSigned;
  assign remSigned    = aSigned % bSigned;
  assign quotUnsigned = a / divisor;
  assign remUnsigned  = a % divisor;

`ifdef MDU_MADD_EN
  logic [63:0] accIn;
  assign accIn = {hi, lo};
`endif

  // Select the result for the op; anything else passes HI/LO through.
  always_comb begin
    {res_hi, res_lo} = {hi, lo};
    div_zero         = 1'b0;
    case (op)
      MDU_MULT:  {res_hi, res_lo} = prodSigned;
      MDU_MULTU: {res_hi, res_lo} = prodUnsigned;
      MDU_DIV: begin
        div_zero         = (b == 32'd0);
        {res_hi, res_lo} = {remSigned, quotSigned};
      end
      MDU_DIVU: begin
        div_zero         = (b == 32'd0);
        {res_hi, res_lo} = {remUnsigned, quotUnsigned};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  {res_hi, res_lo} = accIn + prodSigned;
      MDU_MADDU: {res_hi, res_lo} = accIn + prodUnsigned;
      MDU_MSUB:  {res_hi, res_lo} = accIn - prodSigned;
      MDU_MSUBU: {res_hi, res_lo} = accIn - prodUnsigned;
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: owns HI/LO, computes the result at
// issue, counts down the op latency and commits on completion.
// Define MDU_MADD_EN to accept MADD/MADDU/MSUB/MSUBU (codes 7-10).
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  mdu_ctrl,
  input  logic        result_sel,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  if ((MULT_CYCLES < 1) || (MULT_CYCLES > 15)) begin : gBadMultCycles
    $error("mult_div_unit: MULT_CYCLES must be in 1..15");
  end
  if ((DIV_CYCLES < 1) || (DIV_CYCLES > 15)) begin : gBadDivCycles
    $error("mult_div_unit: DIV_CYCLES must be in 1..15");
  end

  localparam logic [3:0] MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_CNT  = 4'(DIV_CYCLES);

  mduStateE    state;
  mduStateE    stateNext;
  logic [3:0]  cnt;
  logic [31:0] pendHi;
  logic [31:0] pendLo;
  logic        pendSkip;
  logic [31:0] hiReg;
  logic [31:0] loReg;
  logic [31:0] arithHi;
  logic [31:0] arithLo;
  logic        arithDivZero;
  logic        longOp;
  logic        issue;
  logic        commit;

`ifdef MDU_MADD_EN
  assign longOp = isMultOp(mdu_ctrl) || isDivOp(mdu_ctrl) || isMaddOp(mdu_ctrl);
`else
  assign longOp = isMultOp(mdu_ctrl) || isDivOp(mdu_ctrl);
`endif

  mdu_arith uArith (
    .op       (mdu_ctrl),
    .a        (src_a),
    .b        (src_b),
    .hi       (hiReg),
    .lo       (loReg),
    .res_hi   (arithHi),
    .res_lo   (arithLo),
    .div_zero (arithDivZero)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= stateNext;
  end

  // Next-state logic: issue a multi-cycle op from IDLE, finish when cnt hits 1.
  always_comb begin
    stateNext = state;
    issue     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (start && longOp) begin
          issue     = 1'b1;
          stateNext = RUN;
        end
      end
      RUN: begin
        if (cnt == 4'd1) begin
          commit    = 1'b1;
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Latch the computed result and load the latency counter at issue.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= 4'd0;
      pendHi   <= 32'd0;
      pendLo   <= 32'd0;
      pendSkip <= 1'b0;
    end else if (issue) begin
      cnt      <= isDivOp(mdu_ctrl) ? DIV_CNT : MULT_CNT;
      pendHi   <= arithHi;
      pendLo   <= arithLo;
      pendSkip <= arithDivZero;
    end else if (state == RUN) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Architectural HI/LO: commit pending result, or take mthi/mtlo while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hiReg <= 32'd0;
      loReg <= 32'd0;
    end else if (commit) begin
      if (!pendSkip) begin
        hiReg <= pendHi;
        loReg <= pendLo;
      end
    end else if ((state == IDLE) && start) begin
      if (mdu_ctrl == MDU_MTHI) hiReg <= src_a;
      if (mdu_ctrl == MDU_MTLO) loReg <= src_a;
    end
  end

  assign busy   = (state == RUN);
  assign hi     = hiReg;
  assign lo     = loReg;
  assign result = result_sel ? hiReg : loReg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops,
// compared against a plain-arithmetic model of HI/LO and op latency.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int MULT_LAT = DEF_MULT_CYCLES;
  localparam int DIV_LAT  = DEF_DIV_CYCLES;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  mdu_ctrl;
  logic        result_sel;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] hiM;
  logic [31:0] loM;

  mult_div_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .mdu_ctrl   (mdu_ctrl),
    .result_sel (result_sel),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .result     (result),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // The hazard logic must never issue while the unit is busy.
  always @(posedge clk) begin
    if (reset_n === 1'b1) begin
      assert (!(start && busy))
      else begin
        checkCount++;
        $error("[TB] FAIL start_in_run: start=%0b busy=%0b, required no start while busy", start, busy);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  function automatic longint absL(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  // Reference model: updates hiM/loM per the op's architectural effect and
  // returns the number of busy cycles the op should take.
  task automatic refModel(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
    longint     sa;
    longint     sb;
    longint     q;
    longint     r;
    logic [63:0] prod;
    logic [63:0] acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {hiM, loM};
    lat = 0;
    case (op)
      4'd1: begin prod = 64'(sa * sb); {hiM, loM} = prod; lat = MULT_LAT; end
      4'd2: begin prod = {32'h0, a} * {32'h0, b}; {hiM, loM} = prod; lat = MULT_LAT; end
      4'd3: begin
        lat = DIV_LAT;
        if (b != 32'd0) begin
          q = absL(sa) / absL(sb);
          if ((sa < 0) != (sb < 0)) q = -q;
          r = sa - q * sb;
          hiM = r[31:0];
          loM = q[31:0];
        end
      end
      4'd4: begin
        lat = DIV_LAT;
        if (b != 32'd0) begin
          loM = a / b;
          hiM = a % b;
        end
      end
      4'd5: hiM = a;
      4'd6: loM = a;
`ifdef MDU_MADD_EN
      4'd7:  begin prod = 64'(sa * sb); {hiM, loM} = acc + prod; lat = MULT_LAT; end
      4'd8:  begin prod = {32'h0, a} * {32'h0, b}; {hiM, loM} = acc + prod; lat = MULT_LAT; end
      4'd9:  begin prod = 64'(sa * sb); {hiM, loM} = acc - prod; lat = MULT_LAT; end
      4'd10: begin prod = {32'h0, a} * {32'h0, b}; {hiM, loM} = acc - prod; lat = MULT_LAT; end
`endif
      default: ;
    endcase
  endtask

  // Issue one op in the current cycle, wait for completion and check
  // latency, absence of early commit, and the committed HI/LO/result.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] oldHi;
    logic [31:0] oldLo;
    int          lat;
    int          count;
    logic        stable;
    oldHi = hiM;
    oldLo = loM;
    refModel(op, a, b, lat);
    start    = 1'b1;
    mdu_ctrl = op;
    src_a    = a;
    src_b    = b;
    @(posedge clk); #1;
    start    = 1'b0;
    mdu_ctrl = 4'($urandom_range(0, 10));
    src_a    = $urandom;
    src_b    = $urandom;
    count    = 0;
    stable   = 1'b1;
    while (busy && count < 40) begin
      count++;
      if (hi !== oldHi || lo !== oldLo) stable = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput($sformatf("latency_op%0d", op), 32'(count), 32'(lat));
    checkOutput($sformatf("no_early_commit_op%0d", op), {31'd0, stable}, 32'd1);
    checkOutput($sformatf("hi_op%0d", op), hi, hiM);
    checkOutput($sformatf("lo_op%0d", op), lo, loM);
    result_sel = 1'b1; #1;
    checkOutput($sformatf("result_hi_op%0d", op), result, hiM);
    result_sel = 1'b0; #1;
    checkOutput($sformatf("result_lo_op%0d", op), result, loM);
  endtask

  initial begin
    logic [3:0]  rOp;
    logic [31:0] rA;
    logic [31:0] rB;
    hiM        = 32'd0;
    loM        = 32'd0;
    reset_n    = 1'b0;
    start      = 1'b0;
    mdu_ctrl   = 4'd0;
    result_sel = 1'b0;
    src_a      = 32'd0;
    src_b      = 32'd0;

    // Reset state.
    #12;
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_hi", hi, 32'd0);
    checkOutput("reset_lo", lo, 32'd0);
    checkOutput("reset_result", result, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    applyStimulus(MDU_MULT,  32'hFFFF_FFFF, 32'd2);
    applyStimulus(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    applyStimulus(MDU_DIV,   32'hFFFF_FFF9, 32'd2);
    applyStimulus(MDU_DIVU,  32'd7,         32'd2);
    applyStimulus(MDU_MTHI,  32'h1234_5678, 32'd0);
    applyStimulus(MDU_MTHI,  32'hA5A5_A5A5, 32'd0);
    applyStimulus(MDU_MTLO,  32'hA5A5_A5A5, 32'd0);
    applyStimulus(MDU_DIV,   32'd1234,      32'd0);
    applyStimulus(MDU_DIVU,  32'hFFFF_0000, 32'd0);
    applyStimulus(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
    applyStimulus(MDU_DIV,   32'd7,         32'hFFFF_FFFE);
    applyStimulus(MDU_NOP,   32'd55,        32'd66);
    applyStimulus(MDU_MTHI,  32'd0,         32'd0);
    applyStimulus(MDU_MTLO,  32'hFFFF_FFFF, 32'd0);
    applyStimulus(MDU_MADDU, 32'd1,         32'd1);
    applyStimulus(MDU_MSUB,  32'd3,         32'hFFFF_FFFE);

    // Reset in cycle 3 of a divide aborts it and clears HI/LO.
    start    = 1'b1;
    mdu_ctrl = MDU_DIV;
    src_a    = 32'd100;
    src_b    = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    hiM = 32'd0;
    loM = 32'd0;
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_hi", hi, hiM);
    checkOutput("abort_lo", lo, loM);
    #1;
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    checkOutput("abort_no_commit_hi", hi, hiM);
    checkOutput("abort_no_commit_lo", lo, loM);
    checkOutput("abort_idle_busy", {31'd0, busy}, 32'd0);

    // Randomized ops, including zero and small divisors.
    for (int i = 0; i < 40; i++) begin
      rOp = 4'($urandom_range(0, 10));
      rA  = $urandom;
      case ($urandom_range(0, 3))
        0:       rB = 32'd0;
        1:       rB = 32'($urandom_range(1, 20));
        2:       rB = 32'd0 - 32'($urandom_range(1, 20));
        default: rB = $urandom;
      endcase
      applyStimulus(rOp, rA, rB);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
